instruction_fetch_stage: RTL



---
 rtl/instruction_fetch_stage_pkg.sv | 22 ++
 rtl/instruction_fetch_stage_if.sv | 31 +++
 rtl/instruction_fetch_stage_next_pc_select.sv | 54 +++++
 rtl/instruction_fetch_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: FSM state
// encoding, halt cause codes, the NOP word and the default text base.
package mips_fetch_pkg;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  typedef enum logic [1:0] {
    S_BOOT = BOOT,
    S_RUN  = RUN,
    S_HALT = HALT
  } fetch_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_RANGE    = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  localparam logic [31:0] NOP               = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Bus between the fetch stage and its neighbours (decode, hazard unit,
// program memory). The fetch stage is the slave; the surrounding core
// (or a testbench) is the master.
interface instruction_fetch_stage_if;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpRegister;
  logic [31:0] RegisterTarget;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        Halted;
  logic [1:0]  HaltCause;

  modport master (
    output Stall, BranchTaken, BranchTarget, Jump, JumpIndex,
           JumpRegister, RegisterTarget, Instruction,
    input  PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted, HaltCause
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, Jump, JumpIndex,
           JumpRegister, RegisterTarget, Instruction,
    output PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted, HaltCause
  );
endinterface

// File: rtl/instruction_fetch_stage_next_pc_select.sv
// Combinational next-PC selection: picks the redirect target by priority
// (JR > J > branch > sequential) and flags misaligned or out-of-segment
// destinations so the FSM can halt instead of fetching them.
module next_pc_select
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE    = DEFAULT_TEXT_BASE,
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32
) (
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [25:0]           i_jump_index,
  input  logic                  i_jump_register,
  input  logic [DATA_WIDTH-1:0] i_register_target,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic [DATA_WIDTH-1:0] o_next_pc,
  output logic                  o_redirect,
  output logic                  o_misaligned,
  output logic                  o_out_of_range
);

  localparam logic [DATA_WIDTH-1:0] LAST_ADDR =
    DATA_WIDTH'(TEXT_BASE) + DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

  // Carry out of the sequential add marks a wrap past the top of memory.
  logic [DATA_WIDTH:0]   w_seq_sum;
  logic [DATA_WIDTH-1:0] w_jump_target;
  logic [DATA_WIDTH-1:0] w_target;

  assign w_seq_sum     = {1'b0, i_pc} + (DATA_WIDTH+1)'(4);
  assign o_pc_plus4    = w_seq_sum[DATA_WIDTH-1:0];
  assign w_jump_target = {o_pc_plus4[DATA_WIDTH-1:DATA_WIDTH-4], i_jump_index, 2'b00};
  assign o_redirect    = i_jump_register | i_jump | i_branch_taken;

  // Priority mux of the redirect destination.
  always_comb begin
    w_target = i_branch_target;
    if (i_jump_register) begin
      w_target = i_register_target;
    end else if (i_jump) begin
      w_target = w_jump_target;
    end
  end

  assign o_next_pc      = o_redirect ? w_target : o_pc_plus4;
  assign o_misaligned   = o_redirect && (w_target[1:0] != 2'b00);
  assign o_out_of_range = (!o_redirect && w_seq_sum[DATA_WIDTH]) ||
                          (o_next_pc < DATA_WIDTH'(TEXT_BASE)) ||
                          (o_next_pc > LAST_ADDR);

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: PC register, BOOT/RUN/HALT control FSM and
// the IF/ID pipeline register. A bubble is the all-zero IF/ID contents.
module instruction_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE    = DEFAULT_TEXT_BASE,
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_stage_if.slave bus
);

  fetch_state_e          r_state,       w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc,          w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_ifid_instr,  w_ifid_instr_nxt;
  logic [DATA_WIDTH-1:0] r_ifid_pc4,    w_ifid_pc4_nxt;
  logic                  r_ifid_valid,  w_ifid_valid_nxt;
  logic [1:0]            r_halt_cause,  w_halt_cause_nxt;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic                  w_redirect;
  logic                  w_misaligned;
  logic                  w_out_of_range;

  next_pc_select #(
    .TEXT_BASE    (TEXT_BASE),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_next_pc_select (
    .i_pc              (r_pc),
    .i_branch_taken    (bus.BranchTaken),
    .i_branch_target   (bus.BranchTarget),
    .i_jump            (bus.Jump),
    .i_jump_index      (bus.JumpIndex),
    .i_jump_register   (bus.JumpRegister),
    .i_register_target (bus.RegisterTarget),
    .o_pc_plus4        (w_pc_plus4),
    .o_next_pc         (w_next_pc),
    .o_redirect        (w_redirect),
    .o_misaligned      (w_misaligned),
    .o_out_of_range    (w_out_of_range)
  );

  // State, PC and IF/ID registers; reset puts the stage back into BOOT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_BOOT;
      r_pc         <= TEXT_BASE;
      r_ifid_instr <= NOP;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
      r_halt_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_halt_cause <= w_halt_cause_nxt;
    end
  end

  // Next-state and next-register logic; everything holds unless changed.
  // An out-of-range halt only blocks the PC update: the IF/ID register still
  // flushes, holds or loads as it otherwise would, so the last in-segment
  // word reaches decode before HALT clears the pipeline register.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_ifid_valid_nxt = r_ifid_valid;
    w_halt_cause_nxt = r_halt_cause;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_misaligned) begin
          w_state_nxt      = S_HALT;
          w_halt_cause_nxt = CAUSE_MISALIGN;
          w_ifid_instr_nxt = NOP;
          w_ifid_pc4_nxt   = '0;
          w_ifid_valid_nxt = 1'b0;
        end else begin
          if (w_out_of_range) begin
            w_state_nxt      = S_HALT;
            w_halt_cause_nxt = CAUSE_RANGE;
          end else if (w_redirect || !bus.Stall) begin
            w_pc_nxt = w_next_pc;
          end
          if (w_redirect) begin
            w_ifid_instr_nxt = NOP;
            w_ifid_pc4_nxt   = '0;
            w_ifid_valid_nxt = 1'b0;
          end else if (!bus.Stall) begin
            w_ifid_instr_nxt = bus.Instruction;
            w_ifid_pc4_nxt   = w_pc_plus4;
            w_ifid_valid_nxt = 1'b1;
          end
        end
      end
      S_HALT: begin
        w_ifid_instr_nxt = NOP;
        w_ifid_pc4_nxt   = '0;
        w_ifid_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign bus.PC               = r_pc;
  assign bus.IFID_Instruction = r_ifid_instr;
  assign bus.IFID_PCPlus4     = r_ifid_pc4;
  assign bus.IFID_Valid       = r_ifid_valid;
  assign bus.Halted           = (r_state == S_HALT);
  assign bus.HaltCause        = r_halt_cause;

endmodule
